// File: rtl/coarse_sync_search_ctrl_pkg.sv
// coarse_sync_search_ctrl_pkg
//   Shared types and constants for the coarse SYNC search sequencer:
//   FSM state encoding, pattern/threshold/channel/PN widths, the reset
//   (detection-disabled) threshold and the threshold relaxation helper.
package coarse_sync_search_ctrl_pkg;

  localparam int unsigned PATTERN_LEN = 32;
  localparam int unsigned ADDR_W      = $clog2(PATTERN_LEN);
  localparam int unsigned THR_W       = 11;
  localparam int unsigned CHAN_W      = 4;
  localparam int unsigned PN_W        = 32;

  localparam logic [THR_W-1:0] THR_RESET = 11'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SEARCH = 3'd3,
    ST_FOUND  = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // One extra bit catches the borrow; a threshold already below the floor
  // is returned untouched so the floor never raises it.
  function automatic logic [THR_W-1:0] thr_relax(
    input logic [THR_W-1:0] thr,
    input int unsigned      step,
    input int unsigned      floor
  );
    logic [THR_W:0] diff;
    diff = {1'b0, thr} - (THR_W+1)'(step);
    if (thr < THR_W'(floor))
      return thr;
    else if (diff[THR_W] || (diff[THR_W-1:0] < THR_W'(floor)))
      return THR_W'(floor);
    else
      return diff[THR_W-1:0];
  endfunction

endpackage

// File: rtl/coarse_sync_pattern_loader.sv
// coarse_sync_pattern_loader
//   Streams the hop pattern from the hop table into the correlator.
//   Ports:
//     i_clk, i_rst   clock, synchronous active-high reset
//     i_start        one-cycle pulse: begin a load on the next cycle
//     i_abort        kills an in-progress load and the pending strobe
//     i_rdata        hop-table data, valid one cycle after o_raddr
//     o_raddr        hop-table read address, steps 0..PATTERN_LEN-1
//     o_chan         registered hop channel stream
//     o_en           one-cycle strobe aligned with entry 0 on o_chan
//     o_done         high on the last load cycle (entry 31 on o_chan)
module coarse_sync_pattern_loader
  import coarse_sync_search_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CHAN_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [CHAN_W-1:0] o_chan,
  output logic              o_en,
  output logic              o_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic              r_active;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_dv;
  logic              r_dfirst;
  logic [CHAN_W-1:0] r_chan;
  logic              r_en;
  logic              w_done;

  // Address phase spans PATTERN_LEN cycles; two more cover table read
  // latency and the output register.
  assign w_done = r_active && (r_cnt == CNT_W'(PATTERN_LEN + 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_dv     <= 1'b0;
      r_dfirst <= 1'b0;
      r_chan   <= '0;
      r_en     <= 1'b0;
    end else if (i_abort) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_dv     <= 1'b0;
      r_dfirst <= 1'b0;
      r_en     <= 1'b0;
    end else begin
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_addr   <= '0;
      end else if (r_active) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_addr != '1)
          r_addr <= r_addr + 1'b1;
        if (w_done)
          r_active <= 1'b0;
      end
      // Valid/first flags travel alongside the table's one-cycle latency.
      r_dv     <= r_active && (r_cnt < CNT_W'(PATTERN_LEN));
      r_dfirst <= r_active && (r_cnt == '0);
      if (r_dv)
        r_chan <= i_rdata;
      r_en <= r_dfirst;
    end
  end

  assign o_raddr = r_addr;
  assign o_chan  = r_chan;
  assign o_en    = r_en;
  assign o_done  = w_done;

endmodule

// File: rtl/coarse_sync_search_ctrl.sv
// coarse_sync_search_ctrl
//   Sequencer for the four-channel coarse SYNC correlator: loads hop
//   pattern + PN, programs the threshold, runs a bounded search window and
//   retries with a relaxed threshold before reporting failure.
//   Ports:
//     logic_clk_in, logic_rst_in   clock, synchronous active-high reset
//     search_start_in/abort_in     start pulse (IDLE only), level abort
//     pn_code_in, thr_init_in      latched on an accepted start
//     hop_raddr_out/hop_rdata_in   hop-table read port (1-cycle latency)
//     sync_pn_out, sync_hop_chan_out, sync_pn_hop_en_out, decision_term_out
//                                  correlator programming
//     correlate_success_in/peak_in correlator result
//     sync_found_out, sync_peak_out, sync_fail_out  search result
//     busy_out, retry_cnt_out, ctrl_state_out       status
module coarse_sync_search_ctrl
  import coarse_sync_search_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 160,
  parameter int unsigned WINDOW_CYCLES = 20000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned THR_STEP      = 16,
  parameter int unsigned THR_FLOOR     = 64
) (
  input  logic              logic_clk_in,
  input  logic              logic_rst_in,
  input  logic              search_start_in,
  input  logic              search_abort_in,
  input  logic [PN_W-1:0]   pn_code_in,
  input  logic [THR_W-1:0]  thr_init_in,
  output logic [ADDR_W-1:0] hop_raddr_out,
  input  logic [CHAN_W-1:0] hop_rdata_in,
  output logic [PN_W-1:0]   sync_pn_out,
  output logic [CHAN_W-1:0] sync_hop_chan_out,
  output logic              sync_pn_hop_en_out,
  output logic [THR_W-1:0]  decision_term_out,
  input  logic              correlate_success_in,
  input  logic [THR_W-1:0]  correlate_peak_in,
  output logic              sync_found_out,
  output logic [THR_W-1:0]  sync_peak_out,
  output logic              sync_fail_out,
  output logic              busy_out,
  output logic [1:0]        retry_cnt_out,
  output logic [2:0]        ctrl_state_out
);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_cnt;
  logic [1:0]       r_retry;
  logic [THR_W-1:0] r_thr;
  logic [PN_W-1:0]  r_pn;
  logic [THR_W-1:0] r_peak;

  logic w_start_ok;
  logic w_load_done;
  logic w_settle_done;
  logic w_timeout;
  logic w_hit;
  logic w_retry;
  logic w_load_go;

  assign w_start_ok    = (r_state == ST_IDLE) && search_start_in && !search_abort_in;
  assign w_settle_done = (r_state == ST_SETTLE) && (r_cnt == 16'(SETTLE_CYCLES - 1));
  assign w_timeout     = (r_state == ST_SEARCH) && (r_cnt == 16'(WINDOW_CYCLES - 1));
  assign w_hit         = (r_state == ST_SEARCH) && correlate_success_in && !search_abort_in;
  // A hit on the final window cycle takes precedence over the timeout.
  assign w_retry       = w_timeout && !correlate_success_in && !search_abort_in &&
                         (r_retry != 2'(MAX_RETRY));
  assign w_load_go     = w_start_ok || w_retry;

  coarse_sync_pattern_loader u_loader (
    .i_clk   (logic_clk_in),
    .i_rst   (logic_rst_in),
    .i_start (w_load_go),
    .i_abort (search_abort_in),
    .i_rdata (hop_rdata_in),
    .o_raddr (hop_raddr_out),
    .o_chan  (sync_hop_chan_out),
    .o_en    (sync_pn_hop_en_out),
    .o_done  (w_load_done)
  );

  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (search_abort_in) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (search_start_in) w_next = ST_LOAD;
        ST_LOAD:   if (w_load_done) w_next = ST_SETTLE;
        ST_SETTLE: if (w_settle_done) w_next = ST_SEARCH;
        ST_SEARCH: begin
          if (correlate_success_in)
            w_next = ST_FOUND;
          else if (w_timeout)
            w_next = (r_retry == 2'(MAX_RETRY)) ? ST_FAIL : ST_LOAD;
        end
        ST_FOUND:  w_next = ST_IDLE;
        ST_FAIL:   w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sync_found_out = 1'b0;
    sync_fail_out  = 1'b0;
    busy_out       = 1'b0;
    ctrl_state_out = r_state;
    if (r_state == ST_FOUND) sync_found_out = 1'b1;
    if (r_state == ST_FAIL)  sync_fail_out  = 1'b1;
    if (r_state != ST_IDLE)  busy_out       = 1'b1;
  end

  // Shared counter: SETTLE length, then restarts from zero as the window.
  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in) begin
      r_cnt   <= '0;
      r_retry <= '0;
      r_thr   <= THR_RESET;
      r_pn    <= '0;
      r_peak  <= '0;
    end else begin
      if (((r_state == ST_SETTLE) && !w_settle_done) || (r_state == ST_SEARCH))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      if (w_start_ok) begin
        r_pn    <= pn_code_in;
        r_thr   <= thr_init_in;
        r_retry <= '0;
        r_peak  <= '0;
      end
      if (w_hit)
        r_peak <= correlate_peak_in;
      if (w_retry) begin
        r_retry <= r_retry + 1'b1;
        r_thr   <= thr_relax(r_thr, THR_STEP, THR_FLOOR);
      end
    end
  end

  assign sync_pn_out       = r_pn;
  assign decision_term_out = r_thr;
  assign sync_peak_out     = r_peak;
  assign retry_cnt_out     = r_retry;

endmodule

// File: tb/tb_coarse_sync_search_ctrl.sv
// tb_coarse_sync_search_ctrl
//   Scenario-based bench for coarse_sync_search_ctrl. Expected strobe
//   thresholds, hit peaks and failure retry counts are queued when stimulus
//   is driven and popped as the DUT emits the matching output event.
module tb_coarse_sync_search_ctrl;

  localparam int SET = 160;
  localparam int WIN = 600;
  localparam int ATT = 34 + SET + WIN;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] pn;
  logic [10:0] thr_init;
  logic [4:0]  hop_raddr;
  logic [3:0]  hop_rdata;
  logic [31:0] sync_pn;
  logic [3:0]  chan;
  logic        en;
  logic [10:0] dterm;
  logic        succ;
  logic [10:0] peak_in;
  logic        found;
  logic [10:0] peak_out;
  logic        fail;
  logic        busy;
  logic [1:0]  retry;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int found_cyc = -1;
  int fail_cyc  = -1;

  logic [10:0] exp_thr[$];
  logic [10:0] exp_peak[$];
  logic [1:0]  exp_fail[$];

  always #5 clk = ~clk;

  // Hop table: entry k holds k mod 16, one-cycle read latency.
  always @(posedge clk) hop_rdata <= hop_raddr[3:0];

  coarse_sync_search_ctrl #(
    .SETTLE_CYCLES (SET),
    .WINDOW_CYCLES (WIN),
    .MAX_RETRY     (3),
    .THR_STEP      (16),
    .THR_FLOOR     (64)
  ) dut (
    .logic_clk_in         (clk),
    .logic_rst_in         (rst),
    .search_start_in      (start),
    .search_abort_in      (abort),
    .pn_code_in           (pn),
    .thr_init_in          (thr_init),
    .hop_raddr_out        (hop_raddr),
    .hop_rdata_in         (hop_rdata),
    .sync_pn_out          (sync_pn),
    .sync_hop_chan_out    (chan),
    .sync_pn_hop_en_out   (en),
    .decision_term_out    (dterm),
    .correlate_success_in (succ),
    .correlate_peak_in    (peak_in),
    .sync_found_out       (found),
    .sync_peak_out        (peak_out),
    .sync_fail_out        (fail),
    .busy_out             (busy),
    .retry_cnt_out        (retry),
    .ctrl_state_out       (state)
  );

  // Advance one cycle, sample #1 after the edge and retire scoreboard events.
  task automatic tick();
    logic [10:0] e;
    logic [1:0]  r;
    @(posedge clk);
    #1;
    cyc++;
    if (en === 1'b1) begin
      total++;
      if (exp_thr.size() == 0) begin
        bad++; $display("FAIL strobe_unexpected: got strobe thr=%0d at cyc %0d, required none", dterm, cyc);
      end else begin
        e = exp_thr.pop_front();
        if (dterm !== e) begin bad++; $display("FAIL strobe_thr: got %0d required %0d", dterm, e); end
      end
    end
    if (found === 1'b1) begin
      total++;
      found_cyc = cyc;
      if (exp_peak.size() == 0) begin
        bad++; $display("FAIL found_unexpected: got found peak=%0d at cyc %0d, required none", peak_out, cyc);
      end else begin
        e = exp_peak.pop_front();
        if (peak_out !== e) begin bad++; $display("FAIL found_peak: got %0d required %0d", peak_out, e); end
      end
    end
    if (fail === 1'b1) begin
      total++;
      fail_cyc = cyc;
      if (exp_fail.size() == 0) begin
        bad++; $display("FAIL fail_unexpected: got fail pulse at cyc %0d, required none", cyc);
      end else begin
        r = exp_fail.pop_front();
        if (retry !== r) begin bad++; $display("FAIL fail_retry: got %0d required %0d", retry, r); end
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; succ = 1'b0;
    pn = '0; thr_init = '0; peak_in = '0;
    repeat (3) tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d required 0", state); end
    total++; if (dterm !== 11'h7FF) begin bad++; $display("FAIL rst_thr: got %0h required 7ff", dterm); end
    total++; if ({busy, found, fail, en} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b required 0000", {busy, found, fail, en}); end
    total++; if ({sync_pn, chan, hop_raddr, peak_out, retry} !== 54'd0) begin bad++; $display("FAIL rst_data: got %0h required 0", {sync_pn, chan, hop_raddr, peak_out, retry}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load(output int s);
    logic [3:0] ec;
    logic       ee;
    pn = 32'hA5A5_5A5A; thr_init = 11'd300; start = 1'b1;
    s = cyc;
    exp_thr.push_back(11'd300);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      run_to(s + k);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL load_state: got %0d required 1 at S+%0d", state, k); end
      if (k <= 32) begin
        total++; if (hop_raddr !== 5'(k - 1)) begin bad++; $display("FAIL load_addr: got %0d required %0d", hop_raddr, k - 1); end
      end
      if (k >= 3) begin
        ec = 4'((k - 3) % 16);
        ee = (k == 3);
        total++; if (chan !== ec) begin bad++; $display("FAIL load_chan: got %0d required %0d at S+%0d", chan, ec, k); end
        total++; if (en !== ee) begin bad++; $display("FAIL load_en: got %b required %b at S+%0d", en, ee, k); end
      end
    end
    run_to(s + 35);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL settle_entry: got %0d required 2", state); end
    total++; if (dterm !== 11'd300) begin bad++; $display("FAIL load_thr: got %0d required 300", dterm); end
    total++; if (sync_pn !== 32'hA5A5_5A5A) begin bad++; $display("FAIL load_pn: got %0h required a5a55a5a", sync_pn); end
  endtask

  task automatic test_hit(input int s);
    run_to(s + 100);
    succ = 1'b1; peak_in = 11'd5;
    tick();
    succ = 1'b0;
    total++; if (state !== 3'd2) begin bad++; $display("FAIL settle_hit_ignored: got state %0d required 2", state); end
    run_to(s + 34 + SET);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL settle_len: got %0d required 2", state); end
    tick();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL search_entry: got %0d required 3", state); end
    run_to(s + 35 + SET + 500);
    succ = 1'b1; peak_in = 11'd412;
    exp_peak.push_back(11'd412);
    tick();
    succ = 1'b0; peak_in = '0;
    total++; if (state !== 3'd4 || found !== 1'b1) begin bad++; $display("FAIL hit_found: got state %0d found %b required 4/1", state, found); end
    total++; if (peak_out !== 11'd412) begin bad++; $display("FAIL hit_peak: got %0d required 412", peak_out); end
    total++; if (found_cyc !== s + 36 + SET + 500) begin bad++; $display("FAIL hit_latency: got %0d required %0d", found_cyc, s + 36 + SET + 500); end
    tick();
    total++; if (busy !== 1'b0 || found !== 1'b0) begin bad++; $display("FAIL hit_idle: got busy %b found %b required 0/0", busy, found); end
    total++; if (peak_out !== 11'd412) begin bad++; $display("FAIL peak_hold: got %0d required 412", peak_out); end
    total++; if (exp_peak.size() != 0 || exp_thr.size() != 0) begin bad++; $display("FAIL hit_pending: got %0d/%0d required 0/0", exp_peak.size(), exp_thr.size()); end
  endtask

  task automatic test_retry_fail();
    int s;
    pn = 32'h1234_5678; thr_init = 11'd100; start = 1'b1;
    s = cyc;
    exp_thr.push_back(11'd100); exp_thr.push_back(11'd84);
    exp_thr.push_back(11'd68);  exp_thr.push_back(11'd64);
    exp_fail.push_back(2'd3);
    tick();
    start = 1'b0;
    total++; if (peak_out !== 11'd0 || retry !== 2'd0) begin bad++; $display("FAIL start_clear: got peak %0d retry %0d required 0/0", peak_out, retry); end
    run_to(s + ATT + 1);
    total++; if (state !== 3'd1 || retry !== 2'd1 || dterm !== 11'd84) begin bad++; $display("FAIL retry1: got state %0d retry %0d thr %0d required 1/1/84", state, retry, dterm); end
    run_to(s + 4 * ATT + 1);
    total++; if (state !== 3'd5 || fail !== 1'b1 || retry !== 2'd3) begin bad++; $display("FAIL fail_state: got state %0d fail %b retry %0d required 5/1/3", state, fail, retry); end
    total++; if (dterm !== 11'd64) begin bad++; $display("FAIL fail_thr: got %0d required 64", dterm); end
    tick();
    total++; if (busy !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL fail_idle: got busy %b fail %b required 0/0", busy, fail); end
    total++; if (fail_cyc !== s + 4 * ATT + 1) begin bad++; $display("FAIL fail_latency: got %0d required %0d", fail_cyc, s + 4 * ATT + 1); end
    total++; if (exp_thr.size() != 0 || exp_fail.size() != 0) begin bad++; $display("FAIL retry_pending: got %0d/%0d required 0/0", exp_thr.size(), exp_fail.size()); end
  endtask

  task automatic test_abort();
    int s;
    int n;
    thr_init = 11'd200; start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    run_to(s + 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (state !== 3'd0 || busy !== 1'b0 || en !== 1'b0) begin bad++; $display("FAIL abort_load: got state %0d busy %b en %b required 0/0/0", state, busy, en); end
    thr_init = 11'd220; start = 1'b1;
    s = cyc;
    exp_thr.push_back(11'd220);
    tick();
    start = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL restart_after_abort: got %0d required 1", state); end
    n = 0;
    while (state !== 3'd3 && n < 400) begin tick(); n++; end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL abort_wait_search: got %0d required 3", state); end
    run_to(cyc + 50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (state !== 3'd0 || found !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL abort_search: got state %0d found %b fail %b required 0/0/0", state, found, fail); end
    thr_init = 11'd240; start = 1'b1;
    exp_thr.push_back(11'd240);
    tick();
    start = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL restart2: got %0d required 1", state); end
    run_to(cyc + 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_to(cyc + ATT + 10);
    total++; if (state !== 3'd0 || exp_thr.size() != 0) begin bad++; $display("FAIL abort_quiet: got state %0d pending %0d required 0/0", state, exp_thr.size()); end
  endtask

  task automatic test_last_cycle_hit();
    int s;
    pn = 32'h0BAD_BEEF; thr_init = 11'd150; start = 1'b1;
    s = cyc;
    exp_thr.push_back(11'd150);
    tick();
    start = 1'b0;
    run_to(s + 34 + SET + WIN);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL last_cycle_state: got %0d required 3", state); end
    succ = 1'b1; peak_in = 11'd77;
    exp_peak.push_back(11'd77);
    tick();
    succ = 1'b0; peak_in = '0;
    total++; if (state !== 3'd4 || retry !== 2'd0) begin bad++; $display("FAIL last_cycle_found: got state %0d retry %0d required 4/0", state, retry); end
    total++; if (peak_out !== 11'd77) begin bad++; $display("FAIL last_cycle_peak: got %0d required 77", peak_out); end
    run_to(cyc + 40);
    total++; if (state !== 3'd0 || exp_thr.size() != 0 || exp_peak.size() != 0) begin bad++; $display("FAIL last_cycle_after: got state %0d pending %0d/%0d required 0/0/0", state, exp_thr.size(), exp_peak.size()); end
  endtask

  task automatic test_start_abort();
    int s;
    thr_init = 11'd500; pn = 32'h0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (state !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL start_abort_same: got state %0d busy %b required 0/0", state, busy); end
    total++; if (dterm !== 11'd150 || sync_pn !== 32'h0BAD_BEEF) begin bad++; $display("FAIL hold_between: got thr %0d pn %0h required 150/0badbeef", dterm, sync_pn); end
    pn = 32'hCAFE_F00D; thr_init = 11'd250; start = 1'b1;
    s = cyc;
    exp_thr.push_back(11'd250);
    tick();
    start = 1'b0;
    run_to(s + 50);
    pn = 32'h0; thr_init = 11'd999; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== 3'd2 || dterm !== 11'd250 || sync_pn !== 32'hCAFE_F00D) begin bad++; $display("FAIL busy_start: got state %0d thr %0d pn %0h required 2/250/cafef00d", state, dterm, sync_pn); end
    run_to(s + 35 + SET);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL busy_start_search: got %0d required 3", state); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (state !== 3'd0 || exp_thr.size() != 0) begin bad++; $display("FAIL busy_start_end: got state %0d pending %0d required 0/0", state, exp_thr.size()); end
  endtask

  initial begin
    int s;
    test_reset();
    test_load(s);
    test_hit(s);
    test_retry_fail();
    test_abort();
    test_last_cycle_hit();
    test_start_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coarse_sync_search_ctrl.md
# coarse_sync_search_ctrl

Sequencer for the four-channel coarse SYNC correlator. Per search it loads the 32-entry hop pattern and PN code into the correlator and programs the decision threshold. It then runs a bounded search window and reports either a hit with its peak, or failure after a fixed number of threshold-relaxing retries. It sits between the receive slot controller, which issues start/abort, and the correlator, whose pattern, PN and threshold inputs it drives.

## Interface
- SETTLE_CYCLES, 160: idle cycles after pattern load before the window opens; legal minimum 134.
- WINDOW_CYCLES, 20000: search window length in cycles; range 1..65535.
- MAX_RETRY, 3: number of retries after the first attempt; range 0..3.
- THR_STEP, 16: threshold decrement per retry.
- THR_FLOOR, 64: minimum threshold.

Ports:
- logic_clk_in  in  1  200 MHz clock.
- logic_rst_in  in  1  synchronous, active-high reset.
- search_start_in  in  1  one-cycle start pulse.
- search_abort_in  in  1  abort; level-sampled.
- pn_code_in  in  32  PN code; latched on an accepted start.
- thr_init_in  in  11  initial threshold; latched on an accepted start.
- hop_raddr_out  out  5  hop-table read address.
- hop_rdata_in  in  4  hop-table data; valid 1 cycle after its address.
- sync_pn_out  out  32  PN code to the correlator.
- sync_hop_chan_out  out  4  hop channel stream to the correlator.
- sync_pn_hop_en_out  out  1  pattern-load strobe to the correlator.
- decision_term_out  out  11  threshold to the correlator.
- correlate_success_in  in  1  correlator hit.
- correlate_peak_in  in  11  correlator peak.
- sync_found_out  out  1  one-cycle hit pulse.
- sync_peak_out  out  11  captured peak; held until the next start.
- sync_fail_out  out  1  one-cycle failure pulse.
- busy_out  out  1  high in any state except IDLE.
- retry_cnt_out  out  2  current retry index.
- ctrl_state_out  out  3  state encoding.

## Operation
- States and encodings: IDLE=0, LOAD=1, SETTLE=2, SEARCH=3, FOUND=4, FAIL=5.
- IDLE: a start pulse is accepted. On acceptance the block latches the PN code and the initial threshold, clears the retry count, clears sync_peak_out, and goes to LOAD.
- LOAD: hop_raddr_out steps 0..31, one address per cycle. The block registers hop_rdata_in onto sync_hop_chan_out. sync_pn_hop_en_out is high for exactly one cycle, the same cycle that carries entry 0. Entries 1..31 follow on consecutive cycles. After entry 31 the block goes to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to SEARCH and clears the window counter.
- SEARCH: the window counter increments every cycle.
  - correlate_success_in high: capture correlate_peak_in into sync_peak_out and go to FOUND.
  - Counter reaches WINDOW_CYCLES-1 with no hit, and retry count < MAX_RETRY: increment the retry count, set threshold = max(threshold − THR_STEP, THR_FLOOR), and go to LOAD.
  - Counter reaches WINDOW_CYCLES-1 with no hit, and retry count = MAX_RETRY: go to FAIL.
  - A hit on the last window cycle wins over timeout.
- FOUND: pulse sync_found_out, then go to IDLE.
- FAIL: pulse sync_fail_out, then go to IDLE.
- Threshold subtraction is done at 12 bits and clamps at THR_FLOOR. If thr_init_in < THR_FLOOR, the value is kept unchanged and is never raised.
- correlate_success_in is ignored outside SEARCH.
- search_start_in is ignored whenever the block is not in IDLE.
- Abort:
  - search_abort_in high in any state forces IDLE on the next edge.
  - sync_pn_hop_en_out is forced low on that edge.
  - No found or fail pulse is generated.
  - If abort and start arrive in the same cycle, abort wins.
- sync_pn_out and decision_term_out hold their values between searches.

## Timing
- Reset values: state IDLE; all outputs 0, except decision_term_out = 11'h7FF, which disables detection.
- Start sampled at cycle S:
  - LOAD from S+1; hop_raddr_out = k at S+1+k.
  - hop_rdata_in returns entry k at S+2+k.
  - sync_hop_chan_out = entry k at S+3+k; sync_pn_hop_en_out high at S+3 only.
  - SETTLE from S+35.
  - SEARCH from S+35+SETTLE_CYCLES.
- Hit sampled at cycle H: FOUND at H+1, sync_found_out high at H+1, sync_peak_out valid from H+1, IDLE at H+2.
- A retry reload follows the same schedule as a start, counted from the timeout cycle.
- Total worst case: (MAX_RETRY+1)·(34+SETTLE_CYCLES+WINDOW_CYCLES) + 2 cycles.

## Structure
- Shared package holds:
  - state encoding;
  - PATTERN_LEN = 32;
  - threshold width 11;
  - hop channel width 4;
  - PN width 32;
  - reset threshold 11'h7FF.
- Sub-module coarse_sync_pattern_loader: address counter, read-latency pipeline and the en/chan strobe for LOAD.
- The FSM, counters and threshold arithmetic stay in the top level.

## Test plan
- Hop table holds entry k = k mod 16; start with pn=32'hA5A5_5A5A and thr=300 → sync_pn_hop_en_out at S+3; chan values 0,1..15,0..15 on S+3..S+34; decision_term_out=300.
- Hit injected 500 cycles into SEARCH with peak 412 → one sync_found_out pulse, sync_peak_out=412, busy_out falls 2 cycles after the hit.
- No hit, thr=100, MAX_RETRY=3 → 4 LOAD strobes with thresholds 100, 84, 68, 64, then one sync_fail_out pulse and retry_cnt_out=3.
- Abort issued in mid-LOAD, then again in mid-SEARCH → IDLE next cycle, no found or fail pulse, and a new start is accepted the following cycle.
- Hit asserted during SETTLE → ignored; a hit on the final window cycle → FOUND, not retry.
- Start and abort in the same cycle → block stays IDLE; a second start pulse while busy → no effect.
